// File: rtl/game_pkg.sv
// Shared encodings for the 3x3 game: cell/player codes, board size and FSM states.
// Used by the turn controller, the game-state memory and the renderer.
package game_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  localparam int         NUM_CELLS = 9;
  localparam logic [3:0] LAST_CELL = 4'(NUM_CELLS - 1);

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SCAN  = 3'd3,
    ST_WRITE = 3'd4,
    ST_EVAL  = 3'd5,
    ST_OVER  = 3'd6
  } turn_state_e;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/game_turn_controller_timer.sv
// Per-turn cycle counter; counts while enabled and saturates at TURN_CYCLES-1.
// expired is asserted while the count sits at its terminal value.
module turn_timer
  #(
    parameter int TURN_CYCLES = 50_000_000
  )
  (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
  );

  localparam int         TW   = $clog2(TURN_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TURN_CYCLES - 1);

  logic [TW-1:0] count_reg;
  logic [TW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg != LAST)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = (count_reg == LAST);

endmodule

// File: rtl/game_turn_controller.sv
// Turn sequencer for the 3x3 game: validates requested cells, issues the single write
// strobe, tracks the player to move, and auto-places on the first free cell on timeout.
module game_turn_controller
  import game_pkg::*;
  #(
    parameter int TURN_CYCLES = 50_000_000
  )
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic       mem_w_e,
    output logic [3:0] mem_addr,
    output logic       mem_clr,
    input  logic [1:0] mem_rd_state,
    input  logic       win,
    input  logic       full,
    output logic [1:0] cur_player,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       illegal,
    output logic       timeout
  );

  localparam logic [2:0] S_CLEAR = ST_CLEAR;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_CHECK = ST_CHECK;
  localparam logic [2:0] S_SCAN  = ST_SCAN;
  localparam logic [2:0] S_WRITE = ST_WRITE;
  localparam logic [2:0] S_EVAL  = ST_EVAL;
  localparam logic [2:0] S_OVER  = ST_OVER;

  logic [2:0] state_reg,  state_next;
  logic [1:0] player_reg, player_next;
  logic [3:0] addr_reg,   addr_next;
  logic       over_reg,   over_next;
  logic [1:0] winner_reg, winner_next;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  turn_timer #(
    .TURN_CYCLES (TURN_CYCLES)
  ) u_turn_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  assign timer_enable = (state_reg == S_WAIT);

  // new_game pre-empts every state, so illegal/timeout never pulse in that cycle.
  always_comb begin
    state_next  = state_reg;
    player_next = player_reg;
    addr_next   = addr_reg;
    over_next   = over_reg;
    winner_next = winner_reg;
    illegal     = 1'b0;
    timeout     = 1'b0;
    timer_clear = 1'b0;

    if (new_game) begin
      state_next  = S_CLEAR;
      player_next = P1;
      over_next   = 1'b0;
      winner_next = EMPTY;
      timer_clear = 1'b1;
    end else begin
      case (state_reg)
        S_CLEAR: begin
          state_next  = S_WAIT;
          timer_clear = 1'b1;
        end
        S_WAIT: begin
          if (move_valid) begin
            addr_next  = move_pos;
            state_next = S_CHECK;
          end else if (timer_expired) begin
            timeout    = 1'b1;
            addr_next  = 4'd0;
            state_next = S_SCAN;
          end
        end
        S_CHECK: begin
          // Rejection keeps the turn and the running timer.
          if ((addr_reg > LAST_CELL) || (mem_rd_state != EMPTY)) begin
            illegal    = 1'b1;
            state_next = S_WAIT;
          end else begin
            state_next = S_WRITE;
          end
        end
        S_SCAN: begin
          if (mem_rd_state == EMPTY) begin
            state_next = S_WRITE;
          end else if (addr_reg == LAST_CELL) begin
            over_next   = 1'b1;
            winner_next = EMPTY;
            state_next  = S_OVER;
          end else begin
            addr_next = addr_reg + 4'd1;
          end
        end
        S_WRITE: begin
          state_next = S_EVAL;
        end
        S_EVAL: begin
          if (win) begin
            over_next   = 1'b1;
            winner_next = player_reg;
            state_next  = S_OVER;
          end else if (full) begin
            over_next   = 1'b1;
            winner_next = EMPTY;
            state_next  = S_OVER;
          end else begin
            player_next = other_player(player_reg);
            timer_clear = 1'b1;
            state_next  = S_WAIT;
          end
        end
        S_OVER: begin
          state_next = S_OVER;
        end
        default: begin
          state_next = S_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= S_CLEAR;
      player_reg <= P1;
      addr_reg   <= 4'd0;
      over_reg   <= 1'b0;
      winner_reg <= EMPTY;
    end else begin
      state_reg  <= state_next;
      player_reg <= player_next;
      addr_reg   <= addr_next;
      over_reg   <= over_next;
      winner_reg <= winner_next;
    end
  end

  // The clear strobe is held off while reset is asserted so it only fires after release.
  assign mem_clr    = (state_reg == S_CLEAR) && rst;
  assign move_ready = (state_reg == S_WAIT);
  assign mem_w_e    = (state_reg == S_WRITE);
  assign mem_addr   = addr_reg;
  assign cur_player = player_reg;
  assign game_over  = over_reg;
  assign winner     = winner_reg;

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller with a small behavioural board memory;
// move table plus hand sequences for timeout and new_game during WRITE.
module tb_game_turn_controller;

  localparam int TC = 8;

  typedef struct {
    logic       ng;
    logic [3:0] pos;
    logic       ill;
    logic [1:0] player;
    logic       over;
    logic [1:0] win_p;
  } vec_t;

  localparam int LINES [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                                  '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  logic       clk;
  logic       rst;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       mem_w_e;
  logic [3:0] mem_addr;
  logic       mem_clr;
  logic [1:0] mem_rd_state;
  logic       win;
  logic       full;
  logic [1:0] cur_player;
  logic       game_over;
  logic [1:0] winner;
  logic       illegal;
  logic       timeout;

  logic [1:0] cells [0:8];
  vec_t       vecs [12];
  int         n_cmp;
  int         n_bad;

  game_turn_controller #(
    .TURN_CYCLES (TC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .new_game     (new_game),
    .move_valid   (move_valid),
    .move_pos     (move_pos),
    .move_ready   (move_ready),
    .mem_w_e      (mem_w_e),
    .mem_addr     (mem_addr),
    .mem_clr      (mem_clr),
    .mem_rd_state (mem_rd_state),
    .win          (win),
    .full         (full),
    .cur_player   (cur_player),
    .game_over    (game_over),
    .winner       (winner),
    .illegal      (illegal),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory: synchronous clear/write, combinational read and status flags.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
    end else if (mem_w_e && (mem_addr < 4'd9)) begin
      cells[mem_addr] <= cur_player;
    end
  end

  always_comb begin
    mem_rd_state = 2'b00;
    if (mem_addr < 4'd9) mem_rd_state = cells[mem_addr];
    win = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((cells[LINES[l][0]] != 2'b00) && (cells[LINES[l][0]] == cells[LINES[l][1]]) &&
          (cells[LINES[l][1]] == cells[LINES[l][2]]))
        win = 1'b1;
    end
    full = 1'b1;
    for (int i = 0; i < 9; i++) if (cells[i] == 2'b00) full = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic occupied(output int n);
    n = 0;
    for (int i = 0; i < 9; i++) if (cells[i] != 2'b00) n++;
  endtask

  // Called mid-cycle while the DUT is in WAIT; returns mid-cycle in the following WAIT/OVER.
  task automatic apply_vec(input vec_t v, input int idx);
    if (v.ng) begin
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      #3;
      check("ng_clr_pulse", int'(mem_clr), 1);
      tick();
      #3;
      check("ng_ready", int'(move_ready), 1);
    end
    move_valid = 1'b1;
    move_pos   = v.pos;
    tick();
    move_valid = 1'b0;
    #3;
    check("chk_illegal", int'(illegal), int'(v.ill));
    check("chk_ready_low", int'(move_ready), 0);
    if (v.ill) begin
      tick();
      #3;
      check("ill_ready_back", int'(move_ready), 1);
      check("ill_no_write", int'(mem_w_e), 0);
      check("ill_player", int'(cur_player), int'(v.player));
    end else begin
      tick();
      #3;
      check("wr_strobe", int'(mem_w_e), 1);
      check("wr_addr", int'(mem_addr), int'(v.pos));
      tick();
      #3;
      check("eval_no_strobe", int'(mem_w_e), 0);
      check("eval_ready_low", int'(move_ready), 0);
      tick();
      #3;
      check("post_player", int'(cur_player), int'(v.player));
      check("post_over", int'(game_over), int'(v.over));
      check("post_winner", int'(winner), int'(v.win_p));
      check("post_ready", int'(move_ready), int'(!v.over));
    end
    $display("move %0d: pos=%0d illegal=%0b player=%0d over=%0b winner=%0d",
             idx, v.pos, illegal, cur_player, game_over, winner);
  endtask

  initial begin
    int n;
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_pos   = 4'd0;

    // Game 1: centre, two rejections, reply. Game 2: P1 wins row 0. Game 3: set up timeout.
    vecs[0]  = '{ng: 1'b0, pos: 4'd4, ill: 1'b0, player: 2'b10, over: 1'b0, win_p: 2'b00};
    vecs[1]  = '{ng: 1'b0, pos: 4'd4, ill: 1'b1, player: 2'b10, over: 1'b0, win_p: 2'b00};
    vecs[2]  = '{ng: 1'b0, pos: 4'd9, ill: 1'b1, player: 2'b10, over: 1'b0, win_p: 2'b00};
    vecs[3]  = '{ng: 1'b0, pos: 4'd3, ill: 1'b0, player: 2'b01, over: 1'b0, win_p: 2'b00};
    vecs[4]  = '{ng: 1'b1, pos: 4'd0, ill: 1'b0, player: 2'b10, over: 1'b0, win_p: 2'b00};
    vecs[5]  = '{ng: 1'b0, pos: 4'd3, ill: 1'b0, player: 2'b01, over: 1'b0, win_p: 2'b00};
    vecs[6]  = '{ng: 1'b0, pos: 4'd1, ill: 1'b0, player: 2'b10, over: 1'b0, win_p: 2'b00};
    vecs[7]  = '{ng: 1'b0, pos: 4'd4, ill: 1'b0, player: 2'b01, over: 1'b0, win_p: 2'b00};
    vecs[8]  = '{ng: 1'b0, pos: 4'd2, ill: 1'b0, player: 2'b01, over: 1'b1, win_p: 2'b01};
    vecs[9]  = '{ng: 1'b1, pos: 4'd0, ill: 1'b0, player: 2'b10, over: 1'b0, win_p: 2'b00};
    vecs[10] = '{ng: 1'b0, pos: 4'd1, ill: 1'b0, player: 2'b01, over: 1'b0, win_p: 2'b00};
    vecs[11] = '{ng: 1'b0, pos: 4'd2, ill: 1'b0, player: 2'b10, over: 1'b0, win_p: 2'b00};

    repeat (3) tick();
    #3;
    check("rst_player", int'(cur_player), 1);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_clr", int'(mem_clr), 0);
    check("rst_we", int'(mem_w_e), 0);
    check("rst_ready", int'(move_ready), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_illegal", int'(illegal), 0);
    check("rst_timeout", int'(timeout), 0);

    tick();
    rst = 1'b1;
    #3;
    check("boot_clr", int'(mem_clr), 1);
    check("boot_ready_low", int'(move_ready), 0);
    tick();
    #3;
    check("boot_clr_done", int'(mem_clr), 0);
    check("boot_ready", int'(move_ready), 1);
    check("boot_player", int'(cur_player), 1);
    check("boot_timeout", int'(timeout), 0);
    $display("reset released: ready=%0b player=%0d", move_ready, cur_player);

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

    // After the win, a request must be ignored.
    move_valid = 1'b1;
    move_pos   = 4'd5;
    tick();
    move_valid = 1'b0;
    #3;
    for (int c = 0; c < 3; c++) begin
      check("over_ready", int'(move_ready), 0);
      check("over_no_write", int'(mem_w_e), 0);
      check("over_held", int'(game_over), 1);
      tick();
      #3;
    end
    check("over_winner", int'(winner), 1);
    check("over_cell5", int'(cells[5]), 0);
    $display("move ignored after game over: winner=%0d", winner);

    for (int i = 9; i < 12; i++) apply_vec(vecs[i], i);

    // P2 idles; cells 0..2 occupied so the scan lands on cell 3.
    for (int c = 1; c < TC; c++) begin
      check("to_idle", int'(timeout), 0);
      tick();
      #3;
    end
    check("to_pulse", int'(timeout), 1);
    check("to_ready", int'(move_ready), 1);
    tick();
    #3;
    check("scan_timeout_drop", int'(timeout), 0);
    check("scan_ready_low", int'(move_ready), 0);
    check("scan_addr0", int'(mem_addr), 0);
    for (int a = 1; a <= 3; a++) begin
      tick();
      #3;
      check("scan_addr", int'(mem_addr), a);
      check("scan_no_write", int'(mem_w_e), 0);
    end
    tick();
    #3;
    check("auto_we", int'(mem_w_e), 1);
    check("auto_addr", int'(mem_addr), 3);
    tick();
    #3;
    tick();
    #3;
    check("auto_ready", int'(move_ready), 1);
    check("auto_player", int'(cur_player), 1);
    check("auto_cell3", int'(cells[3]), 2);
    $display("timeout auto-move: addr=%0d player=%0d", mem_addr, cur_player);

    // new_game together with a fresh request during WRITE.
    move_valid = 1'b1;
    move_pos   = 4'd5;
    tick();
    move_valid = 1'b0;
    #3;
    tick();
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_pos   = 4'd6;
    #3;
    check("ngw_we", int'(mem_w_e), 1);
    tick();
    new_game   = 1'b0;
    move_valid = 1'b0;
    #3;
    check("ngw_we_drop", int'(mem_w_e), 0);
    check("ngw_clr", int'(mem_clr), 1);
    check("ngw_player", int'(cur_player), 1);
    check("ngw_ready_low", int'(move_ready), 0);
    check("ngw_over", int'(game_over), 0);
    tick();
    #3;
    occupied(n);
    check("ngw_ready", int'(move_ready), 1);
    check("ngw_clr_done", int'(mem_clr), 0);
    check("ngw_board_empty", n, 0);
    check("ngw_player2", int'(cur_player), 1);
    $display("new_game during write: ready=%0b player=%0d occupied=%0d", move_ready, cur_player, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_turn_controller.md
# game_turn_controller

Sequences play on the 3x3 game-state memory: accepts move requests from the input/debounce logic, checks the target cell over the memory read port, and issues the single-cycle write strobe. It then samples `win`/`full`, alternates the current player and enforces a per-turn timeout by auto-placing on the first free cell. It sits between the button/keypad front end and `game_state_memory`, and feeds game status to the VGA renderer.

## Interface
- `TURN_CYCLES`, 50_000_000: cycles allowed per turn before auto-move (1 s at 50 MHz); must be ≥ 2.
- `clk` in 1: single system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `new_game` in 1: one-cycle pulse; restart the game.
- `move_valid` in 1: move request; qualified by `move_ready`.
- `move_pos` in 4: requested cell, 0..8 valid.
- `move_ready` out 1: high only in WAIT.
- `mem_w_e` out 1: write strobe to memory.
- `mem_addr` out 4: shared write/read cell address to memory.
- `mem_clr` out 1: clears the memory, active-high.
- `mem_rd_state` in 2: contents of cell `mem_addr`, combinational read.
- `win`, `full` in 1 each: memory status flags, valid the cycle after a write edge.
- `cur_player` out 2: player to move; 01 = P1, 10 = P2, 00 = empty cell.
- `game_over` out 1: game ended.
- `winner` out 2: winning player; 00 = draw or not over.
- `illegal` out 1: one-cycle pulse; move rejected.
- `timeout` out 1: one-cycle pulse; auto-move started.

## Operation
- FSM states:
  - CLEAR: `mem_clr`=1 for one cycle, then WAIT.
  - WAIT: `move_ready`=1, turn timer counts.
  - CHECK: evaluate the requested cell.
  - SCAN: search for a free cell.
  - WRITE: `mem_w_e`=1.
  - EVAL: sample `win`/`full`.
  - OVER: game ended.
- Reset values: state CLEAR, `cur_player`=01, `mem_addr`=0, all other outputs 0, timer 0.
- WAIT transitions:
  - On `move_valid`, latch `move_pos` into `mem_addr` and go to CHECK.
  - Else, when timer = `TURN_CYCLES`-1, pulse `timeout`, set `mem_addr`=0 and go to SCAN.
- CHECK:
  - If `mem_addr` > 8 or `mem_rd_state` ≠ 00: pulse `illegal`, return to WAIT. Timer is not reset and the same player keeps the turn.
  - Otherwise go to WRITE.
- SCAN: each cycle test `mem_rd_state`.
  - If 00, go to WRITE with `mem_addr` held.
  - Else, if `mem_addr` = 8, go to OVER as a draw.
  - Else increment `mem_addr`.
- WRITE: `mem_w_e`=1 for exactly one cycle, with the write data being `cur_player`. Then go to EVAL.
- EVAL:
  - `win` → OVER, `winner`=`cur_player`, `game_over`=1.
  - Else `full` → OVER, `winner`=00, `game_over`=1.
  - Else toggle `cur_player` (01↔10), clear the timer, go to WAIT.
- OVER: holds all outputs; only `new_game` or `rst` leave it.
- `new_game`, in any state:
  - Next state is CLEAR; `cur_player`=01, `game_over`=0, `winner`=00, timer 0.
  - Takes priority over every other event in the same cycle.
  - A write in progress is abandoned; `mem_w_e` drops next cycle.
- `rst` low overrides `new_game`.

## Timing
- Legal manual move: accept edge → CHECK → WRITE → EVAL → WAIT. `move_ready` is low for exactly 3 cycles, and `mem_w_e` is high in the 2nd cycle after acceptance.
- Illegal move: `move_ready` is low for 1 cycle; `illegal` is asserted in the CHECK cycle.
- Auto-move latency: 1 + k cycles of SCAN, where k is the index of the first free cell, followed by WRITE and EVAL.
- `move_valid` in the same cycle the timer expires: the move wins and the timeout is not taken.
- `move_valid` outside WAIT is ignored and is not queued.
- Timer: width `$clog2(TURN_CYCLES)`. It counts only in WAIT and saturates at `TURN_CYCLES`-1 (it never wraps).

## Structure
- `game_pkg` holds:
  - The player/cell encoding constants (EMPTY, P1, P2).
  - `NUM_CELLS`=9.
  - The FSM state enum.
  - It is shared with `game_state_memory` and the renderer.
- Sub-module `turn_timer`: clear/enable inputs and an `expired` output, parameterised by `TURN_CYCLES`.

## Test plan
- Reset, then the first cycle after release: `mem_clr`=1 for 1 cycle, then `move_ready`=1 with `cur_player`=01 and all other outputs 0.
- P1 `move_pos`=4 on an empty board: `mem_w_e`=1 with `mem_addr`=4 two cycles after accept; `cur_player`=10 after EVAL.
- Move to occupied cell 4: `illegal` pulse, no `mem_w_e`, `cur_player` unchanged. Then `move_pos`=9: `illegal` pulse.
- P1 takes 0, 1, 2 interleaved with P2 takes 3, 4, and the memory raises `win`: `game_over`=1, `winner`=01, and further `move_valid` is ignored.
- `TURN_CYCLES`=8 with cells 0–2 occupied: after 8 idle cycles `timeout` pulses, SCAN walks 0..3, `mem_w_e` fires at `mem_addr`=3, and the turn passes.
- `new_game` asserted in the WRITE cycle together with `move_valid`: `mem_w_e` drops next cycle, `mem_clr` pulses, `cur_player`=01, and the move is ignored.
